// File: rtl/pwm_coord_capture.sv
// Measures the high time of three PWM inputs in microsecond ticks and turns each into a
// saturated 10-bit coordinate, with glitch/over-length rejection and a per-channel stale flag.
module pwm_coord_capture #(
   parameter int TICK_DIV     = 50,
   parameter int MIN_US       = 1000,
   parameter int MIN_VALID_US = 500,
   parameter int MAX_US       = 2500,
   parameter int STALE_US     = 100000
) (
   input  logic       MAX10_CLK1_50,
   input  logic       rst,
   input  logic [2:0] pwm_in,
   output logic [9:0] x_coord,
   output logic [9:0] y_coord,
   output logic [9:0] z_coord,
   output logic [2:0] coord_valid,
   output logic [2:0] pulse_err,
   output logic [2:0] stale
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [11:0]      MIN_C     = 12'(MIN_US);
   localparam logic [11:0]      MINVAL_C  = 12'(MIN_VALID_US);
   localparam logic [11:0]      MAX_C     = 12'(MAX_US);
   localparam logic [16:0]      STALE_C   = 17'(STALE_US);

   typedef enum logic [1:0] {IDLE, HIGH, OVER} state_t;

   // Subtract only after proving us > MIN_C so the 12-bit difference never wraps.
   function automatic logic [9:0] to_coord(input logic [11:0] us);
      logic [11:0] d;
      if (us <= MIN_C) return 10'd0;
      d = us - MIN_C;
      if (d >= 12'd1023) return 10'd1023;
      return d[9:0];
   endfunction

   function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic inc);
      if (inc && (v < MAX_C)) return v + 12'd1;
      return v;
   endfunction

   for (genvar c = 0; c < 3; c++) begin : g_ch
      logic             s1, s2, s3;
      logic             rise_d, fall_d;
      logic [PRE_W-1:0] pre;
      logic             tick;
      logic [11:0]      us_cnt;
      logic [11:0]      us_meas;
      logic [16:0]      idle_cnt;
      state_t           state;
      logic [9:0]       coord;
      logic             upd, err, stale_r;

      assign tick = (pre == PRE_LAST);
      // Width including the tick of the current cycle, so H clocks measure floor(H/TICK_DIV).
      assign us_meas = sat_inc(us_cnt, tick);

      always_ff @(posedge MAX10_CLK1_50) begin
         if (rst) begin
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
            rise_d   <= 1'b0;
            fall_d   <= 1'b0;
            pre      <= '0;
            us_cnt   <= '0;
            idle_cnt <= '0;
            state    <= IDLE;
            coord    <= '0;
            upd      <= 1'b0;
            err      <= 1'b0;
            stale_r  <= 1'b0;
         end else begin
            s1     <= pwm_in[c];
            s2     <= s1;
            s3     <= s2;
            rise_d <= s2 & ~s3;
            fall_d <= ~s2 & s3;
            upd    <= 1'b0;
            err    <= 1'b0;

            if (rise_d || tick) pre <= '0;
            else                pre <= pre + PRE_W'(1);

            if (tick && (idle_cnt < STALE_C)) idle_cnt <= idle_cnt + 17'd1;
            if (idle_cnt == STALE_C) stale_r <= 1'b1;

            case (state)
               IDLE: begin
                  if (rise_d) begin
                     us_cnt <= '0;
                     state  <= HIGH;
                  end
               end
               HIGH: begin
                  us_cnt <= us_meas;
                  if (fall_d) begin
                     state <= IDLE;
                     if ((us_meas >= MINVAL_C) && (us_meas < MAX_C)) begin
                        coord    <= to_coord(us_meas);
                        upd      <= 1'b1;
                        idle_cnt <= '0;
                        stale_r  <= 1'b0;
                     end else begin
                        err <= 1'b1;
                     end
                  end else if (us_cnt == MAX_C) begin
                     state <= OVER;
                  end
               end
               OVER: begin
                  if (fall_d) begin
                     err   <= 1'b1;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign coord_valid[c] = upd;
      assign pulse_err[c]   = err;
      assign stale[c]       = stale_r;
   end

   assign x_coord = g_ch[0].coord;
   assign y_coord = g_ch[1].coord;
   assign z_coord = g_ch[2].coord;

endmodule

// File: tb/tb_pwm_coord_capture.sv
// Scoreboard bench for pwm_coord_capture with a scaled-down tick (2 clocks per us).
module tb_pwm_coord_capture;

   localparam int TD    = 2;
   localparam int STALE = 3000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] pwm = 3'b111;
   logic [9:0] x_coord, y_coord, z_coord;
   logic [2:0] coord_valid, pulse_err, stale;

   pwm_coord_capture #(
      .TICK_DIV(TD), .MIN_US(1000), .MIN_VALID_US(500), .MAX_US(2500), .STALE_US(STALE)
   ) dut (
      .MAX10_CLK1_50(clk), .rst(rst), .pwm_in(pwm),
      .x_coord(x_coord), .y_coord(y_coord), .z_coord(z_coord),
      .coord_valid(coord_valid), .pulse_err(pulse_err), .stale(stale)
   );

   always #10 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         ch;
      bit         is_err;
      logic [9:0] ex, ey, ez;
      longint     due;
   } exp_t;

   exp_t       sb[$];
   logic [9:0] exp_c [3];
   int         total = 0;
   int         bad   = 0;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < 3; c++) begin
            if (coord_valid[c] || pulse_err[c]) begin
               if (sb.size() == 0) begin
                  chk($sformatf("unexpected_strobe_ch%0d", c), 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("strobe_channel", c, e.ch);
                  chk($sformatf("strobe_kind_ch%0d", c), {coord_valid[c], pulse_err[c]},
                      e.is_err ? 2'b01 : 2'b10);
                  chk("x_coord", x_coord, e.ex);
                  chk("y_coord", y_coord, e.ey);
                  chk("z_coord", z_coord, e.ez);
                  chk("strobe_latency", cyc, e.due);
                  if (!e.is_err) chk($sformatf("stale_cleared_ch%0d", c), stale[c], 0);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_c[i] = '0;
   endtask

   // High for h clocks on channel c; the strobe is due 4 edges after the pin falls.
   task automatic pulse(input int c, input int h, input bit is_err, input logic [9:0] newc,
                        output longint due);
      exp_t e;
      @(posedge clk); #1 pwm[c] = 1'b1;
      repeat (h) @(posedge clk);
      #1;
      if (!is_err) exp_c[c] = newc;
      e.ch = c; e.is_err = is_err;
      e.ex = exp_c[0]; e.ey = exp_c[1]; e.ez = exp_c[2];
      e.due = cyc + 4;
      due = e.due;
      sb.push_back(e);
      pwm[c] = 1'b0;
      repeat (12) @(posedge clk);
   endtask

   typedef struct { int c; int h; bit is_err; logic [9:0] coord; } vec_t;

   initial begin
      vec_t   vx [9];
      longint due;

      for (int i = 0; i < 3; i++) exp_c[i] = '0;
      // Reset with all pins high: nothing should be measured.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_x", x_coord, 0);
      chk("reset_y", y_coord, 0);
      chk("reset_z", z_coord, 0);
      chk("reset_valid", coord_valid, 0);
      chk("reset_err", pulse_err, 0);
      chk("reset_stale", stale, 0);
      repeat (5) @(posedge clk);
      #1 pwm = 3'b000;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("partial_first_pulse_x", x_coord, 0);

      pulse(0, 1500 * TD, 1'b0, 10'd500, due);
      pulse(1, 900 * TD, 1'b0, 10'd0, due);
      pulse(2, 2100 * TD, 1'b0, 10'd1023, due);

      // Z stops pulsing: stale appears ~STALE us after its last update.
      while (cyc < due + longint'(STALE * TD - 100)) @(posedge clk);
      @(negedge clk);
      chk("stale_z_early", stale[2], 0);
      while (cyc < due + longint'(STALE * TD + 100)) @(posedge clk);
      @(negedge clk);
      chk("stale_z_set", stale[2], 1);
      pulse(2, 1200 * TD, 1'b0, 10'd200, due);
      @(negedge clk);
      chk("stale_z_after", stale[2], 0);

      vx[0] = '{0, 300 * TD,      1'b1, 10'd0};    // glitch
      vx[1] = '{0, 3000 * TD,     1'b1, 10'd0};    // over-length via OVER
      vx[2] = '{0, 1001 * TD + 1, 1'b0, 10'd1};    // odd clock floors away
      vx[3] = '{0, 1000 * TD + 1, 1'b0, 10'd0};    // exactly MIN_US
      vx[4] = '{0, 500 * TD - 2,  1'b1, 10'd0};    // 499 us
      vx[5] = '{0, 500 * TD,      1'b0, 10'd0};    // exactly MIN_VALID_US
      vx[6] = '{0, 2500 * TD,     1'b1, 10'd0};    // exactly MAX_US
      vx[7] = '{0, 2499 * TD + 1, 1'b0, 10'd1023}; // 2499 us saturates
      vx[8] = '{0, 1750 * TD,     1'b0, 10'd750};
      for (int i = 0; i < 9; i++) pulse(vx[i].c, vx[i].h, vx[i].is_err, vx[i].coord, due);

      // Reset in the middle of an X pulse; the tail must not be measured.
      @(posedge clk); #1 pwm[0] = 1'b1;
      repeat (700 * TD) @(posedge clk);
      do_reset();
      repeat (1000) @(posedge clk);
      #1 pwm[0] = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("reset_midpulse_x", x_coord, 0);
      chk("reset_midpulse_z", z_coord, 0);
      pulse(0, 1200 * TD, 1'b0, 10'd200, due);

      repeat (20) @(posedge clk);
      chk("pending_expectations", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
